vecnorm_sched: RTL and testbench

Column-serial scheduler that shares one vector-norm (root-sum-of-squares) unit across all columns of a ROWS×COLS fixed-point matrix. It replaces COLS parallel norm instances when area matters. On `start` it captures the matrix and issues one column vector per accepted request to the shared unit, with up to MAXOUT requests outstanding. It retires the in-order results into the `f` vector and signals `done`.

---
 rtl/vecnorm_sched_if.sv | 14 +
 rtl/vecnorm_sched.sv | 155 +++++++++++++++
 tb/tb_vecnorm_sched.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vecnorm_sched_if.sv
// Request/result channel between vecnorm_sched (master) and the shared norm unit (slave).
interface vecnorm_sched_if #(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned WIDTH = 32
);
  logic                       nu_req;
  logic [ROWS:1][WIDTH-1:0]   nu_vec;
  logic                       nu_ack;
  logic                       nu_valid;
  logic [WIDTH-1:0]           nu_res;

  modport master (output nu_req, nu_vec, input nu_ack, nu_valid, nu_res);
  modport slave  (input nu_req, nu_vec, output nu_ack, nu_valid, nu_res);
endinterface

// File: rtl/vecnorm_sched.sv
// Column-serial scheduler feeding one shared vector-norm unit; results retire in order into f.
// Optional zero-column skipping is built when VECNORM_SCHED_ZERO_SKIP_EN is defined.
module vecnorm_sched #(
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 2,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] a,
  output logic                           busy,
  output logic                           done,
  output logic [COLS:1][WIDTH-1:0]       f,
  output logic                           err,
  vecnorm_sched_if.master                nu
);
  // Column pointers must be able to hold COLS+1 (one past the last column).
  localparam int unsigned CW = $clog2(COLS + 2);
  localparam int unsigned OW = $clog2(MAXOUT + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                           state_q, state_d;
  logic [ROWS:1][COLS:1][WIDTH-1:0] mat_q, mat_d;
  logic [COLS:1][WIDTH-1:0]         f_q, f_d;
  logic [CW-1:0]                    issue_col_q, issue_col_d;
  logic [CW-1:0]                    retire_col_q, retire_col_d;
  logic [OW-1:0]                    outst_q, outst_d;
  logic                             err_q, err_d;
  logic                             done_q, done_d;
  logic                             issue_skip, retire_skip;
  logic                             xfer, retire, nu_req;
  logic [ROWS:1][WIDTH-1:0]         nu_vec;

`ifdef VECNORM_SCHED_ZERO_SKIP_EN
  logic [COLS:1] mask_q, mask_d, a_zero;

  always_comb begin
    a_zero      = '0;
    issue_skip  = 1'b0;
    retire_skip = 1'b0;
    for (int unsigned c = 1; c <= COLS; c++) begin
      a_zero[c] = 1'b1;
      for (int unsigned r = 1; r <= ROWS; r++) begin
        if (a[r][c] != '0) a_zero[c] = 1'b0;
      end
      if (issue_col_q == CW'(c))  issue_skip  = mask_q[c];
      if (retire_col_q == CW'(c)) retire_skip = mask_q[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask_q <= '0;
    else        mask_q <= mask_d;
  end
`else
  assign issue_skip  = 1'b0;
  assign retire_skip = 1'b0;
`endif

  // nu_req is derived only from registered state, so it cannot drop before nu_ack.
  assign nu_req = (state_q == StRun) && (issue_col_q <= CW'(COLS)) &&
                  (outst_q < OW'(MAXOUT)) && !issue_skip;
  assign xfer   = nu_req && nu.nu_ack;
  assign retire = nu.nu_valid && (outst_q != '0);

  always_comb begin
    nu_vec = '0;
    for (int unsigned c = 1; c <= COLS; c++) begin
      if (issue_col_q == CW'(c)) begin
        for (int unsigned r = 1; r <= ROWS; r++) nu_vec[r] = mat_q[r][c];
      end
    end
  end

  assign nu.nu_req = nu_req;
  assign nu.nu_vec = nu_vec;

  always_comb begin
    state_d      = state_q;
    mat_d        = mat_q;
    f_d          = f_q;
    issue_col_d  = issue_col_q;
    retire_col_d = retire_col_q;
    outst_d      = outst_q;
    err_d        = err_q;
    done_d       = 1'b0;
`ifdef VECNORM_SCHED_ZERO_SKIP_EN
    mask_d       = mask_q;
`endif
    // A result with nothing outstanding is dropped and only flagged.
    if (nu.nu_valid && (outst_q == '0)) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          mat_d        = a;
          issue_col_d  = CW'(1);
          retire_col_d = CW'(1);
          outst_d      = '0;
          err_d        = 1'b0;
`ifdef VECNORM_SCHED_ZERO_SKIP_EN
          mask_d       = a_zero;
`endif
        end
      end
      StRun: begin
        if (xfer || issue_skip) issue_col_d = issue_col_q + 1'b1;
        outst_d = outst_q + OW'(xfer) - OW'(retire);
        if (retire || retire_skip) begin
          for (int unsigned c = 1; c <= COLS; c++) begin
            if (retire_col_q == CW'(c)) f_d[c] = retire_skip ? '0 : nu.nu_res;
          end
          retire_col_d = retire_col_q + 1'b1;
          if (retire_col_q == CW'(COLS)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      mat_q        <= '0;
      f_q          <= '0;
      issue_col_q  <= '0;
      retire_col_q <= '0;
      outst_q      <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mat_q        <= mat_d;
      f_q          <= f_d;
      issue_col_q  <= issue_col_d;
      retire_col_q <= retire_col_d;
      outst_q      <= outst_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign f    = f_q;
  assign err  = err_q;

endmodule

// File: tb/tb_vecnorm_sched.sv
// Directed bench for vecnorm_sched: fixed-latency (L=3) norm-unit models, Q16.16 integer norms.
// Zero-skip scenario is built when VECNORM_SCHED_ZERO_SKIP_EN is defined.
module tb_vecnorm_sched;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] fp(input int x);
    return W'(x) << 16;
  endfunction

  // Integer norm of the integer parts; all-ones when not a perfect square.
  function automatic logic [W-1:0] norm3(input logic [3:1][W-1:0] v);
    int s;
    s = 0;
    for (int r = 1; r <= 3; r++) s += int'(v[r][31:16]) * int'(v[r][31:16]);
    for (int k = 0; k <= 64; k++) if (k * k == s) return W'(k) << 16;
    return '1;
  endfunction

  // DUT0: COLS=2, MAXOUT=4, controllable ack, injectable stray result
  vecnorm_sched_if #(.ROWS(3), .WIDTH(W)) nu0 ();
  logic start0, busy0, done0, err0, ack0, inj_v0;
  logic [W-1:0] inj_r0;
  logic [3:1][2:1][W-1:0] a0;
  logic [2:1][W-1:0] f0;
  logic [2:0] v0_sr;
  logic [2:0][W-1:0] r0_sr;

  vecnorm_sched #(.ROWS(3), .COLS(2), .WIDTH(W), .MAXOUT(4)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .a(a0), .busy(busy0), .done(done0),
    .f(f0), .err(err0), .nu(nu0)
  );
  assign nu0.nu_ack   = ack0;
  assign nu0.nu_valid = v0_sr[2] | inj_v0;
  assign nu0.nu_res   = inj_v0 ? inj_r0 : r0_sr[2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_sr <= '0;
      r0_sr <= '0;
    end else begin
      v0_sr <= {v0_sr[1:0], nu0.nu_req & nu0.nu_ack};
      r0_sr <= {r0_sr[1:0], norm3(nu0.nu_vec)};
    end
  end

  // DUT1: COLS=4, MAXOUT=1, ack tied high
  vecnorm_sched_if #(.ROWS(3), .WIDTH(W)) nu1 ();
  logic start1, busy1, done1, err1;
  logic [3:1][4:1][W-1:0] a1;
  logic [4:1][W-1:0] f1;
  logic [2:0] v1_sr;
  logic [2:0][W-1:0] r1_sr;

  vecnorm_sched #(.ROWS(3), .COLS(4), .WIDTH(W), .MAXOUT(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .a(a1), .busy(busy1), .done(done1),
    .f(f1), .err(err1), .nu(nu1)
  );
  assign nu1.nu_ack   = 1'b1;
  assign nu1.nu_valid = v1_sr[2];
  assign nu1.nu_res   = r1_sr[2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_sr <= '0;
      r1_sr <= '0;
    end else begin
      v1_sr <= {v1_sr[1:0], nu1.nu_req & nu1.nu_ack};
      r1_sr <= {r1_sr[1:0], norm3(nu1.nu_vec)};
    end
  end

`ifdef VECNORM_SCHED_ZERO_SKIP_EN
  // DUT2: COLS=3, MAXOUT=4, ack tied high
  vecnorm_sched_if #(.ROWS(3), .WIDTH(W)) nu2 ();
  logic start2, busy2, done2, err2;
  logic [3:1][3:1][W-1:0] a2;
  logic [3:1][W-1:0] f2;
  logic [2:0] v2_sr;
  logic [2:0][W-1:0] r2_sr;

  vecnorm_sched #(.ROWS(3), .COLS(3), .WIDTH(W), .MAXOUT(4)) u_dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .a(a2), .busy(busy2), .done(done2),
    .f(f2), .err(err2), .nu(nu2)
  );
  assign nu2.nu_ack   = 1'b1;
  assign nu2.nu_valid = v2_sr[2];
  assign nu2.nu_res   = r2_sr[2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_sr <= '0;
      r2_sr <= '0;
    end else begin
      v2_sr <= {v2_sr[1:0], nu2.nu_req & nu2.nu_ack};
      r2_sr <= {r2_sr[1:0], norm3(nu2.nu_vec)};
    end
  end

  task automatic set_col2(input int c, input int x, input int y, input int z);
    a2[1][c] = fp(x); a2[2][c] = fp(y); a2[3][c] = fp(z);
  endtask
`endif

  task automatic set_col0(input int c, input int x, input int y, input int z);
    a0[1][c] = fp(x); a0[2][c] = fp(y); a0[3][c] = fp(z);
  endtask

  task automatic set_col1(input int c, input int x, input int y, input int z);
    a1[1][c] = fp(x); a1[2][c] = fp(y); a1[3][c] = fp(z);
  endtask

  // Pulse start for one edge (cycle 0); returns at the sample point of cycle 1.
  task automatic go(input int d);
    @(negedge clk);
    if (d == 0) start0 = 1'b1;
    else if (d == 1) start1 = 1'b1;
`ifdef VECNORM_SCHED_ZERO_SKIP_EN
    else start2 = 1'b1;
`endif
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
`ifdef VECNORM_SCHED_ZERO_SKIP_EN
    start2 = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ack0 = 1'b1; inj_v0 = 1'b0; inj_r0 = '0;
    a0 = '0; a1 = '0;
`ifdef VECNORM_SCHED_ZERO_SKIP_EN
    start2 = 1'b0; a2 = '0;
`endif
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
    checks++; if (nu0.nu_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", nu0.nu_req); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err0); end
    checks++; if (f0 !== '0) begin errors++; $display("FAIL reset_f0 got %h exp 0", f0); end
    checks++; if (f1 !== '0) begin errors++; $display("FAIL reset_f1 got %h exp 0", f1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] req_mask, busy_mask;
    logic [3:1][W-1:0] ev;
    int done_cyc, done_cnt;
    req_mask = '0; busy_mask = '0; done_cyc = -1; done_cnt = 0;
    ev[1] = fp(3); ev[2] = fp(4); ev[3] = fp(0);
    set_col0(1, 3, 4, 0); set_col0(2, 0, 5, 12);
    ack0 = 1'b1;
    go(0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin
        checks++;
        if (nu0.nu_vec !== ev) begin errors++; $display("FAIL basic_vec got %h exp %h", nu0.nu_vec, ev); end
      end
      req_mask[c]  = nu0.nu_req;
      busy_mask[c] = busy0;
      if (done0) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (c == 2) begin start0 = 1'b1; set_col0(1, 1, 1, 1); set_col0(2, 1, 1, 1); end
      if (c == 3) start0 = 1'b0;
      @(negedge clk);
    end
    checks++; if (req_mask !== 16'h0006) begin errors++; $display("FAIL basic_req got %h exp 0006", req_mask); end
    checks++; if (busy_mask !== 16'h003E) begin errors++; $display("FAIL basic_busy got %h exp 003e", busy_mask); end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL basic_done_cycle got %0d exp 6", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    checks++; if (f0[1] !== fp(5)) begin errors++; $display("FAIL basic_f1 got %h exp %h", f0[1], fp(5)); end
    checks++; if (f0[2] !== fp(13)) begin errors++; $display("FAIL basic_f2 got %h exp %h", f0[2], fp(13)); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err0); end
  endtask

  task automatic test_stall;
    logic [3:1][W-1:0] ev;
    int done_cyc;
    done_cyc = -1;
    ev[1] = fp(0); ev[2] = fp(5); ev[3] = fp(12);
    set_col0(1, 0, 5, 12); set_col0(2, 3, 4, 0);
    ack0 = 1'b0;
    go(0);
    for (int c = 1; c <= 5; c++) begin
      checks++; if (nu0.nu_req !== 1'b1) begin errors++; $display("FAIL stall_req c%0d got %b exp 1", c, nu0.nu_req); end
      checks++; if (nu0.nu_vec !== ev) begin errors++; $display("FAIL stall_vec c%0d got %h exp %h", c, nu0.nu_vec, ev); end
      @(negedge clk);
    end
    ack0 = 1'b1;
    for (int c = 6; c <= 20; c++) begin
      if (done0 && done_cyc < 0) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (done_cyc != 11) begin errors++; $display("FAIL stall_done_cycle got %0d exp 11", done_cyc); end
    checks++; if (f0[1] !== fp(13)) begin errors++; $display("FAIL stall_f1 got %h exp %h", f0[1], fp(13)); end
    checks++; if (f0[2] !== fp(5)) begin errors++; $display("FAIL stall_f2 got %h exp %h", f0[2], fp(5)); end
  endtask

  task automatic test_maxout1;
    int out_m, max_m, done_cyc;
    logic [4:1][W-1:0] ef;
    out_m = 0; max_m = 0; done_cyc = -1;
    set_col1(1, 1, 2, 2); set_col1(2, 2, 3, 6); set_col1(3, 1, 4, 8); set_col1(4, 2, 6, 9);
    ef[1] = fp(3); ef[2] = fp(7); ef[3] = fp(9); ef[4] = fp(11);
    go(1);
    for (int c = 1; c <= 25; c++) begin
      out_m = out_m + int'(nu1.nu_req & nu1.nu_ack) - int'(nu1.nu_valid);
      if (out_m > max_m) max_m = out_m;
      if (done1 && done_cyc < 0) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (max_m != 1) begin errors++; $display("FAIL mo1_inflight got %0d exp 1", max_m); end
    checks++; if (done_cyc != 17) begin errors++; $display("FAIL mo1_done_cycle got %0d exp 17", done_cyc); end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (f1[c] !== ef[c]) begin errors++; $display("FAIL mo1_f%0d got %h exp %h", c, f1[c], ef[c]); end
    end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL mo1_err got %b exp 0", err1); end
  endtask

  task automatic test_reset_mid;
    int done_cyc;
    done_cyc = -1;
    set_col0(1, 3, 4, 0); set_col0(2, 0, 5, 12);
    go(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy0); end
    checks++; if (f0 !== '0) begin errors++; $display("FAIL rmid_f got %h exp 0", f0); end
    checks++; if (nu0.nu_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b exp 0", nu0.nu_req); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done0); end
    @(negedge clk);
    checks++; if (nu0.nu_req !== 1'b0) begin errors++; $display("FAIL rmid_req_hold got %b exp 0", nu0.nu_req); end
    @(negedge clk);
    rst_n = 1'b1;
    go(0);
    for (int c = 1; c <= 10; c++) begin
      if (done0 && done_cyc < 0) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL rmid_done_cycle got %0d exp 6", done_cyc); end
    checks++; if (f0[1] !== fp(5)) begin errors++; $display("FAIL rmid_f1 got %h exp %h", f0[1], fp(5)); end
    checks++; if (f0[2] !== fp(13)) begin errors++; $display("FAIL rmid_f2 got %h exp %h", f0[2], fp(13)); end
  endtask

  task automatic test_idle_valid;
    int done_cyc;
    done_cyc = -1;
    @(negedge clk);
    inj_v0 = 1'b1; inj_r0 = 32'hDEAD_BEEF;
    @(negedge clk);
    inj_v0 = 1'b0;
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL idle_err got %b exp 1", err0); end
    checks++; if (f0[1] !== fp(5)) begin errors++; $display("FAIL idle_f1 got %h exp %h", f0[1], fp(5)); end
    checks++; if (f0[2] !== fp(13)) begin errors++; $display("FAIL idle_f2 got %h exp %h", f0[2], fp(13)); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy0); end
    set_col0(1, 2, 3, 6); set_col0(2, 1, 2, 2);
    go(0);
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL idle_err_clear got %b exp 0", err0); end
    for (int c = 1; c <= 10; c++) begin
      if (done0 && done_cyc < 0) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL idle_done_cycle got %0d exp 6", done_cyc); end
    checks++; if (f0[1] !== fp(7)) begin errors++; $display("FAIL idle_f1_new got %h exp %h", f0[1], fp(7)); end
    checks++; if (f0[2] !== fp(3)) begin errors++; $display("FAIL idle_f2_new got %h exp %h", f0[2], fp(3)); end
  endtask

`ifdef VECNORM_SCHED_ZERO_SKIP_EN
  task automatic test_zero_skip;
    int xf, done_cyc;
    set_col2(1, 3, 4, 0); set_col2(2, 2, 3, 6); set_col2(3, 0, 5, 12);
    go(2);
    repeat (12) @(negedge clk);
    checks++; if (f2[2] !== fp(7)) begin errors++; $display("FAIL zs_pre_f2 got %h exp %h", f2[2], fp(7)); end
    xf = 0; done_cyc = -1;
    set_col2(2, 0, 0, 0);
    go(2);
    for (int c = 1; c <= 15; c++) begin
      if (nu2.nu_req & nu2.nu_ack) xf++;
      if (done2 && done_cyc < 0) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (xf != 2) begin errors++; $display("FAIL zs_transfers got %0d exp 2", xf); end
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL zs_done got none exp pulse"); end
    checks++; if (f2[1] !== fp(5)) begin errors++; $display("FAIL zs_f1 got %h exp %h", f2[1], fp(5)); end
    checks++; if (f2[2] !== '0) begin errors++; $display("FAIL zs_f2 got %h exp 0", f2[2]); end
    checks++; if (f2[3] !== fp(13)) begin errors++; $display("FAIL zs_f3 got %h exp %h", f2[3], fp(13)); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_maxout1;
    test_reset_mid;
    test_idle_valid;
`ifdef VECNORM_SCHED_ZERO_SKIP_EN
    test_zero_skip;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
